// File: rtl/smi_arbiter.sv
// Round-robin arbiter that funnels three SMI (MDIO) requesters into a single SMI engine.
// Optional WAIT-state timeout is compiled in with `define SMI_ARB_TIMEOUT_EN.
module smi_arbiter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  wr,
    input  logic [14:0] phy_addr_in,
    input  logic [14:0] reg_addr_in,
    input  logic [47:0] wdata_in,
    output logic [2:0]  ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [4:0]  smi_phy_addr,
    output logic [4:0]  smi_reg_addr,
    output logic [15:0] smi_write_data,
    output logic        smi_write_req,
    output logic        smi_read_req,
    input  logic [15:0] smi_read_data,
    input  logic        smi_data_valid,
    input  logic        smi_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  last_gnt_q, last_gnt_d;
    logic        wr_q, wr_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  pick;

`ifdef SMI_ARB_TIMEOUT_EN
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // First requester found after the last winner, wrapping 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] c;
        logic       found;
        c       = last;
        found   = 1'b0;
        rr_next = 2'd0;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (!found && r[c]) begin
                found   = 1'b1;
                rr_next = c;
            end
        end
    endfunction

    assign pick = rr_next(last_gnt_q, req);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        phy_d      = phy_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef SMI_ARB_TIMEOUT_EN
        err_d      = err_q;
        cnt_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    wr_d       = wr[pick];
                    phy_d      = phy_addr_in[5*int'(pick) +: 5];
                    reg_d      = reg_addr_in[5*int'(pick) +: 5];
                    wdata_d    = wdata_in[16*int'(pick) +: 16];
                    rdata_d    = 16'h0000;
`ifdef SMI_ARB_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Writes never take read data, so they always report 16'h0000.
                if (smi_data_valid && !wr_q) rdata_d = smi_read_data;
`ifdef SMI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
                if (smi_done) begin
                    state_d = RESP;
                end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 16'hFFFF;
                end
`else
                if (smi_done) state_d = RESP;
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 2'd0;
            last_gnt_q <= 2'd2;
            wr_q       <= 1'b0;
            phy_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef SMI_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            phy_q      <= phy_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef SMI_ARB_TIMEOUT_EN
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        ack = 3'b000;
        if (state_q == RESP) ack[gnt_q] = 1'b1;
    end

    assign busy           = (state_q != IDLE);
    assign smi_read_req   = (state_q == ISSUE) && !wr_q;
    assign smi_write_req  = (state_q == ISSUE) && wr_q;
    assign smi_phy_addr   = phy_q;
    assign smi_reg_addr   = reg_q;
    assign smi_write_data = wdata_q;
    assign rdata          = rdata_q;
`ifdef SMI_ARB_TIMEOUT_EN
    assign err            = err_q;
`else
    assign err            = 1'b0;
`endif

endmodule

// File: doc/smi_arbiter.md
SMI_ARBITER -- requirements
Module: smi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd200_000, meaning the WAIT-state cycles before a transaction is aborted (used only with SMI_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 3 bits: per-requester level request, bit i = requester i.
REQ-005 SHALL have port wr, input, 3 bits: per-requester operation, 1 = write, 0 = read.
REQ-006 SHALL have port phy_addr_in, input, 15 bits: packed 5-bit PHY addresses, requester i at [5i+4:5i].
REQ-007 SHALL have port reg_addr_in, input, 15 bits: packed 5-bit register addresses, same packing as phy_addr_in.
REQ-008 SHALL have port wdata_in, input, 48 bits: packed 16-bit write data, requester i at [16i+15:16i].
REQ-009 SHALL have port ack, output, 3 bits: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rdata, output, 16 bits: read result, valid only while any ack bit is high.
REQ-011 SHALL have port err, output, 1 bit: timeout flag, qualified by ack.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 SHALL have ports smi_phy_addr (5), smi_reg_addr (5), smi_write_data (16), smi_write_req (1), smi_read_req (1), all outputs to the SMI engine.
REQ-014 SHALL have ports smi_read_data (16), smi_data_valid (1), smi_done (1), all inputs from the SMI engine.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req bit is high, the FSM SHALL grant one requester, latch its wr, addresses and wdata into the smi_* address/data outputs, and move to ISSUE; otherwise it stays in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_gnt+1) mod 3; last_gnt updates on grant.
REQ-018 ISSUE: exactly one of smi_read_req or smi_write_req (selected by the latched wr) SHALL be high for this single cycle, then the FSM moves to WAIT.
REQ-019 WAIT: smi_data_valid SHALL capture smi_read_data into rdata; smi_done SHALL move the FSM to RESP.
REQ-020 smi_done and smi_data_valid SHALL be ignored outside WAIT.
REQ-021 RESP: ack[granted] SHALL be high for one cycle, then the FSM returns to IDLE.
REQ-022 A write transaction SHALL return rdata = 16'h0000.
REQ-023 Requesters lower req on the edge that samples ack=1; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-024 smi_phy_addr, smi_reg_addr and smi_write_data SHALL hold stable from ISSUE through RESP.
REQ-025 Changes to req or command inputs after grant SHALL NOT affect the transaction in progress.
REQ-026 Minimum latency from req high in IDLE to ack SHALL be 3 cycles plus the engine's done latency.

Reset
REQ-027 rst high SHALL asynchronously force: state IDLE; ack=0, err=0, busy=0, rdata=0, smi_read_req=0, smi_write_req=0, smi_* address/data=0; last_gnt=2, so requester 0 has first priority.
REQ-028 rst asserted mid-transaction SHALL abort it with no ack issued; that requester must re-request.

Configuration
REQ-029 With macro SMI_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYCLES without smi_done, the FSM SHALL go to RESP with err=1 and rdata=16'hFFFF, and the counter SHALL clear outside WAIT.
REQ-030 Without SMI_ARB_TIMEOUT_EN, WAIT SHALL persist until smi_done, err SHALL be tied to 0, and no counter SHALL exist.

Verification
REQ-031 Read: req=3'b001, wr=0, phy 5'd1, reg 5'd1; engine returns 16'h796D with data_valid then done -> smi_read_req is one pulse the cycle after grant; ack=3'b001 with rdata=16'h796D.
REQ-032 Contention: req=3'b111 held after each ack -> grants in order 0,1,2,0; each ack is a single pulse; busy stays high between back-to-back transactions only outside IDLE.
REQ-033 Write: requester 2, wr=1, reg 5'h1F, wdata 16'hA5A5 -> smi_write_req is one pulse; smi_write_data=16'hA5A5; ack=3'b100 with rdata=16'h0000.
REQ-034 Timeout (SMI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): engine never asserts done -> ack exactly 100 WAIT cycles after WAIT entry, err=1, rdata=16'hFFFF.
REQ-035 Reset mid-WAIT: rst pulse -> all outputs 0 immediately; no ack; next req=3'b110 grants requester 1 first.
REQ-036 Spurious smi_done asserted in IDLE and ISSUE -> no state change and no ack.
